// File: rtl/app_csr_run_ctrl_pkg.sv
// Shared types and constants for the app CSR run controller.
package app_csr_ctrl_pkg;

    // Default width of the run cycle counter.
    localparam int unsigned CntBitsDefault = 40;

    // Width of one CSR slot and the slot indices within the packed buses.
    localparam int unsigned CsrWidth = 64;
    localparam int unsigned CsrCmd   = 0;
    localparam int unsigned CsrBase  = 1;
    localparam int unsigned CsrLen   = 2;
    localparam int unsigned CsrCount = 3;

    // Command bits decoded from a CSR0 write.
    localparam int unsigned CmdStartBit = 0;
    localparam int unsigned CmdAbortBit = 1;
    localparam int unsigned CmdClearBit = 2;

    // Status bit positions in the CSR0 read value.
    localparam int unsigned StatStateLsb   = 0;
    localparam int unsigned StatDoneBit    = 8;
    localparam int unsigned StatErrorBit   = 9;
    localparam int unsigned StatAbortedBit = 10;
    localparam int unsigned StatCfgErrBit  = 11;
    localparam int unsigned StatWrBusyBit  = 12;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

    typedef struct packed {
        logic wr_busy;
        logic cfg_err;
        logic aborted;
        logic error;
        logic done;
    } status_t;

    // Build the CSR0 read word from the run state and sticky flags.
    function automatic logic [CsrWidth-1:0] pack_csr0(state_e st, status_t s);
        logic [CsrWidth-1:0] v;
        v = '0;
        v[StatStateLsb +: 3] = st;
        v[StatDoneBit]       = s.done;
        v[StatErrorBit]      = s.error;
        v[StatAbortedBit]    = s.aborted;
        v[StatCfgErrBit]     = s.cfg_err;
        v[StatWrBusyBit]     = s.wr_busy;
        return v;
    endfunction

endpackage

// File: rtl/app_csr_run_ctrl_if.sv
// Host CSR bus plus engine control/handshake signals of the run controller.
interface app_csr_run_ctrl_if #(
    parameter int unsigned NUM_CSRS = 4
);
    logic [NUM_CSRS-1:0]    csr_wr_en;
    logic [64*NUM_CSRS-1:0] csr_wr_data;
    logic [64*NUM_CSRS-1:0] csr_rd_data;
    logic                   eng_start;
    logic                   eng_abort;
    logic [63:0]            eng_base;
    logic [31:0]            eng_len;
    logic                   eng_done;
    logic                   eng_error;

    // Host and engine side, which drive writes and completions.
    modport master (
        output csr_wr_en,
        output csr_wr_data,
        output eng_done,
        output eng_error,
        input  csr_rd_data,
        input  eng_start,
        input  eng_abort,
        input  eng_base,
        input  eng_len
    );

    // Controller side.
    modport slave (
        input  csr_wr_en,
        input  csr_wr_data,
        input  eng_done,
        input  eng_error,
        output csr_rd_data,
        output eng_start,
        output eng_abort,
        output eng_base,
        output eng_len
    );
endinterface

// File: rtl/app_csr_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats enable.
module csr_mgr_sat_counter
    import app_csr_ctrl_pkg::*;
#(
    parameter int unsigned Width = CntBitsDefault
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    // Next count: clear, else step until all-ones and hold there.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/app_csr_run_ctrl.sv
// Host-CSR driven run controller: decodes commands, launches and tracks one
// engine run, and reports sticky status plus a run cycle count.
module app_csr_run_ctrl
    import app_csr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CSRS = 4,
    parameter int unsigned CNT_BITS = CntBitsDefault
) (
    input logic               clk,
    input logic               reset_n,
    app_csr_run_ctrl_if.slave bus
);

    state_e                   state_q, state_d;
    status_t                  status_q, status_d;
    logic [63:0]              base_q, base_d;
    logic [31:0]              len_q, len_d;
    logic                     eng_start_q;
    logic                     eng_abort_q;
    logic [64*NUM_CSRS-1:0]   rd_q;
    logic [CNT_BITS-1:0]      cnt;
    logic                     cnt_clear;
    logic                     cnt_en;

    logic [NUM_CSRS-1:0]      wr_en;
    logic                     start_cmd;
    logic                     abort_cmd;
    logic                     clear_cmd;
    logic                     start_go;
    logic                     cfg_open;
    logic [63:0]              base_wr;
    logic [31:0]              len_wr;

    assign wr_en     = bus.csr_wr_en;
    assign start_cmd = wr_en[CsrCmd] & bus.csr_wr_data[CsrCmd*CsrWidth + CmdStartBit];
    assign abort_cmd = wr_en[CsrCmd] & bus.csr_wr_data[CsrCmd*CsrWidth + CmdAbortBit];
    assign clear_cmd = wr_en[CsrCmd] & bus.csr_wr_data[CsrCmd*CsrWidth + CmdClearBit];
    assign base_wr   = bus.csr_wr_data[CsrBase*CsrWidth +: 64];
    assign len_wr    = bus.csr_wr_data[CsrLen*CsrWidth +: 32];

    // An abort in the same write cancels the start, even where abort itself is a no-op.
    assign start_go  = start_cmd & ~abort_cmd;
    // Configuration may only change while no run is in flight.
    assign cfg_open  = (state_q == StIdle) || (state_q == StDone);
    assign cnt_en    = (state_q == StStart) || (state_q == StRun) || (state_q == StDrain);

    // Next-state, config loads and sticky status updates.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_clear = 1'b0;

        if (wr_en[CsrBase]) begin
            if (cfg_open) begin
                base_d = base_wr;
            end else begin
                status_d.wr_busy = 1'b1;
            end
        end
        if (wr_en[CsrLen]) begin
            if (cfg_open) begin
                len_d = len_wr;
            end else begin
                status_d.wr_busy = 1'b1;
            end
        end

        case (state_q)
            StIdle, StDone: begin
                // Start is judged against the length held before this cycle's write.
                if (start_go) begin
                    if (len_q != '0) begin
                        state_d          = StStart;
                        status_d.done    = 1'b0;
                        status_d.error   = 1'b0;
                        status_d.aborted = 1'b0;
                        cnt_clear        = 1'b1;
                    end else begin
                        status_d.cfg_err = 1'b1;
                    end
                end else if (clear_cmd) begin
                    state_d   = StIdle;
                    status_d  = '0;
                    cnt_clear = 1'b1;
                end
            end
            StStart: begin
                state_d = abort_cmd ? StDrain : StRun;
            end
            StRun: begin
                // A completion already reported wins over a late abort; nothing left to drain.
                if (bus.eng_done || bus.eng_error) begin
                    state_d = StDone;
                    if (bus.eng_done) begin
                        status_d.done = 1'b1;
                    end
                    if (bus.eng_error) begin
                        status_d.error = 1'b1;
                    end
                end else if (abort_cmd) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (bus.eng_done || bus.eng_error) begin
                    state_d          = StDone;
                    status_d.aborted = 1'b1;
                    if (bus.eng_done) begin
                        status_d.done = 1'b1;
                    end
                    if (bus.eng_error) begin
                        status_d.error = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, config and registered outputs; read data trails internal state by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            status_q    <= '0;
            base_q      <= '0;
            len_q       <= '0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            base_q      <= base_d;
            len_q       <= len_d;
            eng_start_q <= (state_d == StStart);
            eng_abort_q <= (state_d == StDrain);
            rd_q        <= {64'(cnt), {32'd0, len_q}, base_q, pack_csr0(state_q, status_q)};
        end
    end

    csr_mgr_sat_counter #(
        .Width (CNT_BITS)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .count_o (cnt)
    );

    assign bus.eng_start   = eng_start_q;
    assign bus.eng_abort   = eng_abort_q;
    assign bus.eng_base    = base_q;
    assign bus.eng_len     = len_q;
    assign bus.csr_rd_data = rd_q;

endmodule

// File: tb/tb_app_csr_run_ctrl.sv
// Directed and random checks of app_csr_run_ctrl against a cycle-level reference model.
module tb_app_csr_run_ctrl;
    import app_csr_ctrl_pkg::*;

    localparam longint unsigned CntMax = (64'd1 << 40) - 64'd1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    app_csr_run_ctrl_if #(.NUM_CSRS(4)) bus ();
    app_csr_run_ctrl_if #(.NUM_CSRS(4)) bus4 ();

    app_csr_run_ctrl #(.NUM_CSRS(4), .CNT_BITS(40)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    app_csr_run_ctrl #(.NUM_CSRS(4), .CNT_BITS(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_start = 0;
    int n_abort = 0;

    // Reference model state.
    state_e           m_state;
    logic             m_done, m_err, m_abt, m_cfg, m_busy;
    logic [63:0]      m_base;
    logic [31:0]      m_len;
    longint unsigned  m_cnt;
    logic [255:0]     m_rd;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_csr0();
        return (64'(m_busy) << 12) | (64'(m_cfg) << 11) | (64'(m_abt) << 10) |
               (64'(m_err) << 9) | (64'(m_done) << 8) | 64'(m_state);
    endfunction

    task automatic model_reset();
        m_state = StIdle;
        m_done = 0; m_err = 0; m_abt = 0; m_cfg = 0; m_busy = 0;
        m_base = '0; m_len = '0; m_cnt = 0; m_rd = '0;
    endtask

    // One clock edge of the controller's rules, applied to the sampled inputs.
    task automatic model_step(input logic [3:0] en, input logic [255:0] d,
                              input logic dn, input logic er);
        logic [255:0] nrd;
        logic quiet, s, a, c;
        logic [31:0] old_len;
        nrd = {64'(m_cnt), 32'd0, m_len, m_base, exp_csr0()};
        quiet = (m_state == StIdle) || (m_state == StDone);
        s = en[0] & d[0];
        a = en[0] & d[1];
        c = en[0] & d[2];
        old_len = m_len;
        if (en[1]) begin
            if (quiet) m_base = d[127:64];
            else m_busy = 1;
        end
        if (en[2]) begin
            if (quiet) m_len = d[159:128];
            else m_busy = 1;
        end
        if (!quiet && m_cnt < CntMax) m_cnt++;
        if (quiet) begin
            if (s && !a) begin
                if (old_len != 0) begin
                    m_state = StStart; m_done = 0; m_err = 0; m_abt = 0; m_cnt = 0;
                end else begin
                    m_cfg = 1;
                end
            end else if (c) begin
                m_state = StIdle; m_done = 0; m_err = 0; m_abt = 0; m_cfg = 0; m_busy = 0;
                m_cnt = 0;
            end
        end else if (m_state == StStart) begin
            m_state = a ? StDrain : StRun;
        end else if (m_state == StRun) begin
            if (dn || er) begin
                m_state = StDone; m_done |= dn; m_err |= er;
            end else if (a) begin
                m_state = StDrain;
            end
        end else begin
            if (dn || er) begin
                m_state = StDone; m_abt = 1; m_done |= dn; m_err |= er;
            end
        end
        m_rd = nrd;
    endtask

    // Advance one clock, update the model, then compare all main-DUT outputs.
    task automatic tick();
        logic [3:0] en;
        logic [255:0] d;
        logic dn, er;
        en = bus.csr_wr_en; d = bus.csr_wr_data; dn = bus.eng_done; er = bus.eng_error;
        @(posedge clk);
        model_step(en, d, dn, er);
        #1;
        bus.csr_wr_en = '0;
        bus.eng_done = 1'b0;
        bus.eng_error = 1'b0;
        chk("eng_start", 256'(bus.eng_start), 256'(m_state == StStart));
        chk("eng_abort", 256'(bus.eng_abort), 256'(m_state == StDrain));
        chk("eng_base", 256'(bus.eng_base), 256'(m_base));
        chk("eng_len", 256'(bus.eng_len), 256'(m_len));
        chk("csr_rd_data", bus.csr_rd_data, m_rd);
        if (bus.eng_start) n_start++;
        if (bus.eng_abort) n_abort++;
    endtask

    task automatic wr(input int idx, input logic [63:0] val);
        bus.csr_wr_en = 4'(1 << idx);
        bus.csr_wr_data = '0;
        bus.csr_wr_data[64*idx +: 64] = val;
        tick();
    endtask

    initial begin
        model_reset();
        bus.csr_wr_en = '0; bus.csr_wr_data = '0; bus.eng_done = 0; bus.eng_error = 0;
        bus4.csr_wr_en = '0; bus4.csr_wr_data = '0; bus4.eng_done = 0; bus4.eng_error = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_eng_start", 256'(bus.eng_start), 256'(0));
        chk("rst_eng_abort", 256'(bus.eng_abort), 256'(0));
        chk("rst_eng_base", 256'(bus.eng_base), 256'(0));
        chk("rst_eng_len", 256'(bus.eng_len), 256'(0));
        chk("rst_rd", bus.csr_rd_data, 256'(0));
        #10 reset_n = 1'b1;

        // Normal run: launch, complete 20 cycles after the launch pulse.
        wr(1, 64'h1000);
        wr(2, 64'd8);
        n_start = 0;
        wr(0, 64'h1);
        repeat (20) tick();
        bus.eng_done = 1'b1;
        tick();
        tick();
        chk("run_start_pulses", 256'(n_start), 256'(1));
        chk("run_base", 256'(bus.eng_base), 256'(64'h1000));
        chk("run_len", 256'(bus.eng_len), 256'(8));
        chk("run_done_bit", 256'(bus.csr_rd_data[8]), 256'(1));
        chk("run_state", 256'(bus.csr_rd_data[2:0]), 256'(StDone));
        chk("run_cycles", 256'(bus.csr_rd_data[255:192]), 256'(21));

        // Clear from DONE.
        wr(0, 64'h4);
        tick();
        chk("clr_csr0", 256'(bus.csr_rd_data[63:0]), 256'(0));
        chk("clr_cycles", 256'(bus.csr_rd_data[255:192]), 256'(0));

        // Zero-length start is refused.
        wr(2, 64'd0);
        n_start = 0;
        wr(0, 64'h1);
        tick();
        chk("zlen_no_start", 256'(n_start), 256'(0));
        chk("zlen_state", 256'(bus.csr_rd_data[2:0]), 256'(StIdle));
        chk("zlen_cfg_err", 256'(bus.csr_rd_data[11]), 256'(1));

        // Busy base write and abort during RUN.
        wr(2, 64'd8);
        wr(0, 64'h1);
        tick();
        wr(1, 64'hdead_beef);
        chk("busy_base_kept", 256'(bus.eng_base), 256'(64'h1000));
        n_abort = 0;
        wr(0, 64'h2);
        repeat (4) tick();
        bus.eng_done = 1'b1;
        tick();
        tick();
        chk("abort_cycles", 256'(n_abort), 256'(5));
        chk("abort_aborted", 256'(bus.csr_rd_data[10]), 256'(1));
        chk("abort_done", 256'(bus.csr_rd_data[8]), 256'(1));
        chk("abort_wr_busy", 256'(bus.csr_rd_data[12]), 256'(1));

        // Simultaneous done and error.
        wr(0, 64'h4);
        wr(0, 64'h1);
        tick();
        bus.eng_done = 1'b1;
        bus.eng_error = 1'b1;
        tick();
        tick();
        chk("both_done", 256'(bus.csr_rd_data[8]), 256'(1));
        chk("both_error", 256'(bus.csr_rd_data[9]), 256'(1));
        chk("both_not_aborted", 256'(bus.csr_rd_data[10]), 256'(0));

        // Reset in the middle of a run.
        wr(0, 64'h1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_eng_abort", 256'(bus.eng_abort), 256'(0));
        chk("mid_rst_eng_start", 256'(bus.eng_start), 256'(0));
        chk("mid_rst_eng_base", 256'(bus.eng_base), 256'(0));
        chk("mid_rst_eng_len", 256'(bus.eng_len), 256'(0));
        chk("mid_rst_rd", bus.csr_rd_data, 256'(0));
        model_reset();
        #3 reset_n = 1'b1;

        // Random traffic.
        repeat (400) begin
            for (int i = 0; i < 8; i++) bus.csr_wr_data[32*i +: 32] = $urandom();
            bus.csr_wr_data[159:128] = 32'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) bus.csr_wr_en[i] = ($urandom_range(0, 4) == 0);
            bus.eng_done = ($urandom_range(0, 7) == 0);
            bus.eng_error = ($urandom_range(0, 11) == 0);
            tick();
        end

        // Narrow counter saturates.
        bus4.csr_wr_data = '0;
        bus4.csr_wr_data[128 +: 32] = 32'd1;
        bus4.csr_wr_en = 4'b0100;
        tick();
        bus4.csr_wr_data = '0;
        bus4.csr_wr_data[0] = 1'b1;
        bus4.csr_wr_en = 4'b0001;
        tick();
        bus4.csr_wr_en = '0;
        repeat (20) tick();
        bus4.eng_done = 1'b1;
        tick();
        bus4.eng_done = 1'b0;
        tick();
        chk("sat_cycles", 256'(bus4.csr_rd_data[255:192]), 256'(15));
        chk("sat_state", 256'(bus4.csr_rd_data[2:0]), 256'(StDone));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
